// File: rtl/bcd_counter_pkg.sv
// Purpose: shared types, constants and modulus helpers for the BCD modulo counter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bcd_counter_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;

    // Tens digit of the terminal value MODULUS-1.
    function automatic bcd_digit_t top_tens(input int modulus);
        return bcd_digit_t'((modulus - 1) / 10);
    endfunction

    // Ones digit of the terminal value MODULUS-1.
    function automatic bcd_digit_t top_ones(input int modulus);
        return bcd_digit_t'((modulus - 1) % 10);
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// Purpose: one registered BCD digit with clear/load/inc/dec and a terminal-count flag.
// Latency: 1 cycle from control to q_o.
// Backpressure: none; controls are single-cycle strobes, priority clr > load > inc > dec.
// Ports: clk_i/rst_i (sync, active-high), clr_i, load_i + load_val_i, inc_i, dec_i,
//        q_o (current digit), tc_o (digit equals TOP).
module bcd_digit
    import bcd_counter_pkg::*;
#(
    parameter bcd_digit_t TOP = BCD_MAX
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       clr_i,
    input  logic       load_i,
    input  bcd_digit_t load_val_i,
    input  logic       inc_i,
    input  logic       dec_i,
    output bcd_digit_t q_o,
    output logic       tc_o
);

    bcd_digit_t q_q, q_d;

    // inc wraps TOP -> 0 and dec wraps 0 -> TOP, so the ones digit
    // (TOP = 9) handles its own 9->0 / 0->9 rollover.
    always_comb begin
        q_d = q_q;
        if (clr_i) begin
            q_d = '0;
        end else if (load_i) begin
            q_d = load_val_i;
        end else if (inc_i) begin
            q_d = (q_q == TOP) ? '0 : q_q + 4'd1;
        end else if (dec_i) begin
            q_d = (q_q == '0) ? TOP : q_q - 4'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o  = q_q;
    assign tc_o = (q_q == TOP);

endmodule

// File: rtl/bcd_modulo_counter.sv
// Purpose: two-digit BCD counter 0..MODULUS-1 with preset load and one-cycle carry/borrow/load_err pulses.
// Latency: 1 cycle, all outputs registered.
// Backpressure: none; en is a per-cycle step strobe, priority reset > load > en > hold.
// Ports: clkinput, reset (sync, active-high), en, up, load, load_tens, load_ones,
//        tens/ones (count), carry (up-wrap), borrow (down-wrap), load_err (preset rejected).
// Build option: define BCD_COUNTER_DOWN_EN to enable down counting via up=0 and the borrow pulse;
//        otherwise the counter only counts up, up is ignored and borrow is tied low.
module bcd_modulo_counter
    import bcd_counter_pkg::*;
#(
    parameter int MODULUS = 60
) (
    input  logic       clkinput,
    input  logic       reset,
    input  logic       en,
    input  logic       up,
    input  logic       load,
    input  logic [3:0] load_tens,
    input  logic [3:0] load_ones,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       carry,
    output logic       borrow,
    output logic       load_err
);

    localparam bcd_digit_t TOP_TENS = top_tens(MODULUS);
    localparam bcd_digit_t TOP_ONES = top_ones(MODULUS);
    localparam logic [7:0] MOD_VAL  = 8'(MODULUS);

    bcd_digit_t tens_q, ones_q;
    logic       tens_tc, ones_tc;
    logic [7:0] value, load_value;
    logic       corrupt, at_max, load_ok;

    logic       clr_all, ld_all;
    bcd_digit_t ld_tens, ld_ones;
    logic       ones_inc, ones_dec, tens_inc, tens_dec;
    logic       carry_q, carry_d;
    logic       load_err_q, load_err_d;

    assign value      = {4'd0, tens_q} * 8'd10 + {4'd0, ones_q};
    assign load_value = {4'd0, load_tens} * 8'd10 + {4'd0, load_ones};
    assign load_ok    = (load_tens <= BCD_MAX) && (load_ones <= BCD_MAX) && (load_value < MOD_VAL);
    // Any state that is not legal BCD within range is scrubbed on the next step.
    assign corrupt    = (tens_q > BCD_MAX) || (ones_q > BCD_MAX) || (value >= MOD_VAL);
    assign at_max     = tens_tc && (ones_q == TOP_ONES);

`ifdef BCD_COUNTER_DOWN_EN
    logic borrow_q, borrow_d;
`else
    logic unused_up;
    assign unused_up = up;
`endif

    always_comb begin
        clr_all    = 1'b0;
        ld_all     = 1'b0;
        ld_tens    = '0;
        ld_ones    = '0;
        ones_inc   = 1'b0;
        ones_dec   = 1'b0;
        tens_inc   = 1'b0;
        tens_dec   = 1'b0;
        carry_d    = 1'b0;
        load_err_d = 1'b0;
`ifdef BCD_COUNTER_DOWN_EN
        borrow_d   = 1'b0;
`endif
        if (load) begin
            if (load_ok) begin
                ld_all  = 1'b1;
                ld_tens = load_tens;
                ld_ones = load_ones;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (en) begin
            if (corrupt) begin
                clr_all = 1'b1;
            end
`ifdef BCD_COUNTER_DOWN_EN
            else if (!up) begin
                if (value == 8'd0) begin
                    ld_all   = 1'b1;
                    ld_tens  = TOP_TENS;
                    ld_ones  = TOP_ONES;
                    borrow_d = 1'b1;
                end else begin
                    // Ones rolls 0 -> 9 inside the digit; tens follows on that rollover.
                    ones_dec = 1'b1;
                    tens_dec = (ones_q == '0);
                end
            end
`endif
            else if (at_max) begin
                clr_all = 1'b1;
                carry_d = 1'b1;
            end else begin
                ones_inc = 1'b1;
                tens_inc = ones_tc;
            end
        end
    end

    bcd_digit #(.TOP(BCD_MAX)) u_ones (
        .clk_i      (clkinput),
        .rst_i      (reset),
        .clr_i      (clr_all),
        .load_i     (ld_all),
        .load_val_i (ld_ones),
        .inc_i      (ones_inc),
        .dec_i      (ones_dec),
        .q_o        (ones_q),
        .tc_o       (ones_tc)
    );

    bcd_digit #(.TOP(TOP_TENS)) u_tens (
        .clk_i      (clkinput),
        .rst_i      (reset),
        .clr_i      (clr_all),
        .load_i     (ld_all),
        .load_val_i (ld_tens),
        .inc_i      (tens_inc),
        .dec_i      (tens_dec),
        .q_o        (tens_q),
        .tc_o       (tens_tc)
    );

    always_ff @(posedge clkinput) begin
        if (reset) begin
            carry_q    <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            carry_q    <= carry_d;
            load_err_q <= load_err_d;
        end
    end

`ifdef BCD_COUNTER_DOWN_EN
    always_ff @(posedge clkinput) begin
        if (reset) begin
            borrow_q <= 1'b0;
        end else begin
            borrow_q <= borrow_d;
        end
    end
    assign borrow = borrow_q;
`else
    assign borrow = 1'b0;
`endif

    assign tens     = tens_q;
    assign ones     = ones_q;
    assign carry    = carry_q;
    assign load_err = load_err_q;

endmodule
